// File: rtl/seg7_scan_decoder_if.sv
// Multiplexed 7-segment bus plus the rebuilt-frame outputs of the scan decoder.
// The master drives the display bus; the slave is the decoder that monitors it.
interface seg7_scan_decoder_if;
    logic [6:0]  seg;
    logic [7:0]  digit;
    logic [55:0] frame_raw;
    logic [31:0] frame_code;
    logic        frame_valid;
    logic        err_multi;
    logic        err_unknown;
    logic        stall;

    modport master (
        output seg, digit,
        input  frame_raw, frame_code, frame_valid, err_multi, err_unknown, stall
    );

    modport slave (
        input  seg, digit,
        output frame_raw, frame_code, frame_valid, err_multi, err_unknown, stall
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Monitors an active-low 8-digit multiplexed 7-segment bus and rebuilds the
// displayed frame as raw patterns and decoded character codes.
module seg7_scan_decoder #(
    parameter int SETTLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 400000
) (
    input  logic               clk,
    input  logic               reset,
    seg7_scan_decoder_if.slave bus
);

    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int IW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] ST_WAIT   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    function automatic logic [3:0] zero_count(input logic [7:0] d);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, ~d[i]};
        end
        return n;
    endfunction

    function automatic logic [2:0] low_index(input logic [7:0] d);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!d[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    function automatic logic [3:0] decode(input logic [6:0] p);
        logic [3:0] c;
        case (p)
            7'b1111111: c = 4'h0;
            7'b1001000: c = 4'h1;
            7'b0100100: c = 4'h2;
            7'b1001111: c = 4'h3;
            7'b0001001: c = 4'h4;
            7'b0001000: c = 4'h5;
            7'b0111001: c = 4'h6;
            default:    c = 4'hF;
        endcase
        return c;
    endfunction

    logic [14:0]   sync1_q, sync1_d, s2_q, s2_d, prev_q, prev_d;
    logic [SW-1:0] stab_cnt_q, stab_cnt_d;
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
    logic [1:0]    state_q, state_d;
    logic [7:0]    mask_q, mask_d;
    logic [55:0]   raw_slots_q, raw_slots_d, frame_raw_q, frame_raw_d;
    logic [31:0]   code_slots_q, code_slots_d, frame_code_q, frame_code_d;
    logic          frame_valid_q, frame_valid_d;
    logic          err_multi_q, err_multi_d, err_unknown_q, err_unknown_d;
    logic          stall_q, stall_d;

    logic [6:0] s2_seg_s;
    logic [7:0] s2_dig_s, prev_dig_s, cap_bit_s;
    logic [3:0] dig_zeros_s, cap_code_s;
    logic [2:0] cap_idx_s;
    logic       stable_s, settled_s, one_hot_s, capture_s, timeout_hit_s;

    // Next-state logic: synchroniser, settle counter, FSM, slot capture, frame assembly, timeout.
    always_comb begin
        sync1_d       = {bus.seg, bus.digit};
        s2_d          = sync1_q;
        prev_d        = s2_q;
        stab_cnt_d    = stab_cnt_q;
        idle_cnt_d    = idle_cnt_q;
        state_d       = state_q;
        mask_d        = mask_q;
        raw_slots_d   = raw_slots_q;
        code_slots_d  = code_slots_q;
        frame_raw_d   = frame_raw_q;
        frame_code_d  = frame_code_q;
        frame_valid_d = 1'b0;
        err_multi_d   = err_multi_q;
        err_unknown_d = err_unknown_q;
        stall_d       = stall_q;
        capture_s     = 1'b0;

        s2_seg_s      = s2_q[14:8];
        s2_dig_s      = s2_q[7:0];
        prev_dig_s    = prev_q[7:0];
        stable_s      = (s2_q == prev_q);
        settled_s     = (stab_cnt_q == SW'(SETTLE_CYC));
        dig_zeros_s   = zero_count(s2_dig_s);
        one_hot_s     = (dig_zeros_s == 4'd1);
        cap_idx_s     = low_index(s2_dig_s);
        cap_bit_s     = 8'd1 << cap_idx_s;
        cap_code_s    = decode(s2_seg_s);
        timeout_hit_s = (idle_cnt_q == IW'(TIMEOUT_CYC));

        if (!stable_s) begin
            stab_cnt_d = '0;
        end else if (!settled_s) begin
            stab_cnt_d = stab_cnt_q + SW'(1);
        end else begin
            stab_cnt_d = stab_cnt_q;
        end

        case (state_q)
            ST_WAIT: begin
                if (one_hot_s) begin
                    state_d = ST_SETTLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_SETTLE: begin
                if (!one_hot_s) begin
                    state_d = ST_WAIT;
                end else if (settled_s) begin
                    capture_s = 1'b1;
                    state_d   = ST_HOLD;
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            ST_HOLD: begin
                if (s2_dig_s != prev_dig_s) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: state_d = ST_WAIT;
        endcase

        for (int k = 0; k < 8; k++) begin
            if (capture_s && (cap_idx_s == 3'(k))) begin
                raw_slots_d[7*k +: 7]  = s2_seg_s;
                code_slots_d[4*k +: 4] = cap_code_s;
            end else begin
                raw_slots_d[7*k +: 7]  = raw_slots_q[7*k +: 7];
                code_slots_d[4*k +: 4] = code_slots_q[4*k +: 4];
            end
        end

        if (capture_s && (cap_code_s == 4'hF)) begin
            err_unknown_d = 1'b1;
        end else begin
            err_unknown_d = err_unknown_q;
        end

        if (settled_s && (dig_zeros_s >= 4'd2)) begin
            err_multi_d = 1'b1;
        end else begin
            err_multi_d = err_multi_q;
        end

        // Publish uses the slot contents from before this edge; a same-edge capture starts the next frame.
        if (mask_q == 8'hFF) begin
            frame_raw_d   = raw_slots_q;
            frame_code_d  = code_slots_q;
            frame_valid_d = 1'b1;
            mask_d        = capture_s ? cap_bit_s : 8'h00;
        end else if (capture_s) begin
            mask_d = mask_q | cap_bit_s;
        end else if (timeout_hit_s) begin
            mask_d = 8'h00;
        end else begin
            mask_d = mask_q;
        end

        if (capture_s) begin
            idle_cnt_d = '0;
            stall_d    = 1'b0;
        end else if (timeout_hit_s) begin
            idle_cnt_d = idle_cnt_q;
            stall_d    = 1'b1;
        end else begin
            idle_cnt_d = idle_cnt_q + IW'(1);
            stall_d    = stall_q;
        end
    end

    // State registers with asynchronous reset to the blank/idle condition.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q       <= 15'h7FFF;
            s2_q          <= 15'h7FFF;
            prev_q        <= 15'h7FFF;
            stab_cnt_q    <= '0;
            idle_cnt_q    <= '0;
            state_q       <= ST_WAIT;
            mask_q        <= 8'h00;
            raw_slots_q   <= {56{1'b1}};
            code_slots_q  <= 32'h0000_0000;
            frame_raw_q   <= {56{1'b1}};
            frame_code_q  <= 32'h0000_0000;
            frame_valid_q <= 1'b0;
            err_multi_q   <= 1'b0;
            err_unknown_q <= 1'b0;
            stall_q       <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            s2_q          <= s2_d;
            prev_q        <= prev_d;
            stab_cnt_q    <= stab_cnt_d;
            idle_cnt_q    <= idle_cnt_d;
            state_q       <= state_d;
            mask_q        <= mask_d;
            raw_slots_q   <= raw_slots_d;
            code_slots_q  <= code_slots_d;
            frame_raw_q   <= frame_raw_d;
            frame_code_q  <= frame_code_d;
            frame_valid_q <= frame_valid_d;
            err_multi_q   <= err_multi_d;
            err_unknown_q <= err_unknown_d;
            stall_q       <= stall_d;
        end
    end

    assign bus.frame_raw   = frame_raw_q;
    assign bus.frame_code  = frame_code_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.err_multi   = err_multi_q;
    assign bus.err_unknown = err_unknown_q;
    assign bus.stall       = stall_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: scans letter patterns onto the bus and
// checks rebuilt frames, capture latency, error flags, timeout and reset.
module tb_seg7_scan_decoder;

    localparam int SETTLE  = 16;
    localparam int TIMEOUT = 300;
    localparam int DWELL   = 40;

    localparam logic [6:0] P_BLANK = 7'h7F;
    localparam logic [6:0] P_H     = 7'h48;
    localparam logic [6:0] P_S     = 7'h24;
    localparam logic [6:0] P_I     = 7'h4F;
    localparam logic [6:0] P_N     = 7'h09;
    localparam logic [6:0] P_A     = 7'h08;
    localparam logic [6:0] P_T     = 7'h39;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   fv_cnt = 0;
    int   fv_base = 0;

    logic [6:0] tab1 [0:7] = '{P_H, P_S, P_I, P_N, P_A, P_T, P_BLANK, P_BLANK};
    logic [6:0] tab2 [0:7] = '{P_T, P_A, P_N, P_I, P_S, P_H, P_BLANK, P_T};

    seg7_scan_decoder_if bus_if ();

    seg7_scan_decoder #(.SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus_if.frame_valid === 1'b1) fv_cnt = fv_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan(input int k, input logic [6:0] pat);
        logic [7:0] oh;
        oh = 8'd1 << k;
        bus_if.digit = ~oh;
        bus_if.seg   = pat;
        tick(DWELL);
    endtask

    task automatic gap(input int n);
        bus_if.digit = 8'hFF;
        bus_if.seg   = P_BLANK;
        tick(n);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_raw"},   64'(bus_if.frame_raw), 64'({56{1'b1}}));
        check_eq({tag, "_code"},  64'(bus_if.frame_code), 64'h0);
        check_eq({tag, "_valid"}, 64'(bus_if.frame_valid), 64'h0);
        check_eq({tag, "_multi"}, 64'(bus_if.err_multi), 64'h0);
        check_eq({tag, "_unk"},   64'(bus_if.err_unknown), 64'h0);
        check_eq({tag, "_stall"}, 64'(bus_if.stall), 64'h0);
    endtask

    initial begin
        bus_if.digit = 8'hFF;
        bus_if.seg   = P_BLANK;
        tick(3);
        check_reset_values("reset");
        reset = 1'b0;
        tick(5);

        // T1: full scan of H S I N A T blank blank
        fv_base = fv_cnt;
        for (int i = 0; i < 8; i++) scan(i, tab1[i]);
        check_eq("t1_pulses", 64'(fv_cnt - fv_base), 64'd1);
        check_eq("t1_code", 64'(bus_if.frame_code), 64'h0065_4321);
        check_eq("t1_raw", 64'(bus_if.frame_raw),
                 64'({P_BLANK, P_BLANK, P_T, P_A, P_N, P_I, P_S, P_H}));
        check_eq("t1_flags", 64'({bus_if.err_multi, bus_if.err_unknown, bus_if.stall}), 64'h0);

        // T2: all positions but 2, then a 10-cycle glitch on position 2 must not capture
        fv_base = fv_cnt;
        for (int i = 0; i < 8; i++) begin
            if (i != 2) scan(i, tab1[i]);
        end
        bus_if.digit = 8'hFB;
        bus_if.seg   = P_I;
        tick(10);
        gap(DWELL);
        check_eq("t2_no_capture", 64'(fv_cnt - fv_base), 64'd0);

        // T3: clean step onto position 2 completes the frame; capture at edge SETTLE+4
        bus_if.digit = 8'hFB;
        bus_if.seg   = P_I;
        tick(SETTLE + 4);
        check_eq("t3_before", 64'(bus_if.frame_valid), 64'h0);
        tick(1);
        check_eq("t3_valid", 64'(bus_if.frame_valid), 64'h1);
        check_eq("t3_code", 64'(bus_if.frame_code), 64'h0065_4321);
        tick(1);
        check_eq("t3_pulse_end", 64'(bus_if.frame_valid), 64'h0);

        // T4: two digit enables low and stable -> err_multi, no capture
        fv_base = fv_cnt;
        bus_if.digit = 8'hFC;
        bus_if.seg   = P_H;
        tick(100);
        check_eq("t4_multi", 64'(bus_if.err_multi), 64'h1);
        check_eq("t4_no_frame", 64'(fv_cnt - fv_base), 64'd0);
        for (int i = 0; i < 8; i++) scan(i, tab2[i]);
        check_eq("t4_pulses", 64'(fv_cnt - fv_base), 64'd1);
        check_eq("t4_code", 64'(bus_if.frame_code), 64'h6012_3456);
        check_eq("t4_raw", 64'(bus_if.frame_raw),
                 64'({P_T, P_BLANK, P_H, P_S, P_I, P_N, P_A, P_T}));
        check_eq("t4_multi_sticky", 64'(bus_if.err_multi), 64'h1);

        // T5: stall after a partial frame discards it
        fv_base = fv_cnt;
        for (int i = 0; i < 5; i++) scan(i, tab2[i]);
        tick(TIMEOUT + 10);
        check_eq("t5_stall", 64'(bus_if.stall), 64'h1);
        check_eq("t5_no_frame", 64'(fv_cnt - fv_base), 64'd0);
        for (int i = 5; i < 8; i++) scan(i, tab1[i]);
        check_eq("t5_partial_dropped", 64'(fv_cnt - fv_base), 64'd0);
        check_eq("t5_stall_clear", 64'(bus_if.stall), 64'h0);
        for (int i = 0; i < 5; i++) scan(i, tab1[i]);
        check_eq("t5_pulses", 64'(fv_cnt - fv_base), 64'd1);
        check_eq("t5_code", 64'(bus_if.frame_code), 64'h0065_4321);

        // T6: unknown pattern on position 4
        fv_base = fv_cnt;
        for (int i = 0; i < 8; i++) scan(i, (i == 4) ? 7'h00 : tab1[i]);
        check_eq("t6_pulses", 64'(fv_cnt - fv_base), 64'd1);
        check_eq("t6_code", 64'(bus_if.frame_code), 64'h006F_4321);
        check_eq("t6_raw4", 64'(bus_if.frame_raw[34:28]), 64'h0);
        check_eq("t6_unknown", 64'(bus_if.err_unknown), 64'h1);

        // Reset in the middle of a frame
        for (int i = 0; i < 5; i++) scan(i, tab1[i]);
        bus_if.digit = 8'hFF;
        bus_if.seg   = P_BLANK;
        reset = 1'b1;
        #1;
        check_reset_values("t6_rst");
        tick(2);
        reset = 1'b0;
        tick(5);
        fv_base = fv_cnt;
        for (int i = 5; i < 8; i++) scan(i, tab1[i]);
        check_eq("t6_fresh_mask", 64'(fv_cnt - fv_base), 64'd0);
        for (int i = 0; i < 5; i++) scan(i, tab1[i]);
        check_eq("t6_after_rst", 64'(fv_cnt - fv_base), 64'd1);
        check_eq("t6_after_code", 64'(bus_if.frame_code), 64'h0065_4321);
        check_eq("t6_unk_cleared", 64'(bus_if.err_unknown), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
